int8_dot_sequencer: RTL

- Sequential front/back end for the 16-input int8 MAC tree.
- Accepts a stream of signed int8 (a,b) operand pairs and packs each group of 8 pairs into the tree operand registers.
- Samples the tree's 32-bit chunk sum, accumulates across cfg_len chunks, and returns one saturated 32-bit dot product through a valid/ready result port.

---
 rtl/int8_dot_sequencer_if.sv | 29 ++
 rtl/int8_dot_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/int8_dot_sequencer_if.sv
// int8_dot_sequencer_if
//   Operand stream and result port of the int8 dot-product sequencer.
//   Operand side: in_valid/in_ready handshake carrying signed int8 a/b.
//   Result side : res_valid/res_ready handshake carrying the saturated
//                 dot product (res_data) and the sticky saturation flag.
//   master: the producer of operands / consumer of results (environment).
//   slave : the sequencer itself.
interface int8_dot_sequencer_if #(
  parameter int ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             res_sat;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data, res_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data, res_sat
  );
endinterface

// File: rtl/int8_dot_sequencer.sv
// int8_dot_sequencer
//   Front/back end for the 16-input int8 MAC tree. Packs groups of LANES
//   signed (a,b) operand pairs into the tree operand registers, samples the
//   combinational tree sum once per chunk, accumulates cfg_len chunks with
//   saturation and returns the result through a valid/ready port.
//
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   start, cfg_len  job start and chunk count (sampled in IDLE only)
//   busy            high whenever the FSM is not IDLE
//   io (slave)      operand stream in_* and result port res_*
//   tree_a, tree_b  registered operands, lane i at [8i+7:8i]
//   tree_sum        combinational tree output for tree_a/tree_b
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// LOAD  | accepting operand pairs into lane lane_cnt (in_ready=1)
// MAC   | one cycle: acc <= sat(acc + tree_sum), chunk_cnt++
// OUT   | result presented, waiting for res_ready
module int8_dot_sequencer #(
  parameter int LANES = 8,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               busy,
  int8_dot_sequencer_if.slave io,
  output logic [8*LANES-1:0] tree_a,
  output logic [8*LANES-1:0] tree_b,
  input  logic [ACC_W-1:0]   tree_sum
);

  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ACC_W-1:0]  ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic [ACC_W-1:0]   acc_q,       acc_d;
  logic               sat_q,       sat_d;
  logic [LANE_W-1:0]  lane_cnt_q,  lane_cnt_d;
  logic [LEN_W-1:0]   chunk_cnt_q, chunk_cnt_d;
  logic [LEN_W-1:0]   len_q,       len_d;
  logic [8*LANES-1:0] tree_a_q,    tree_a_d;
  logic [8*LANES-1:0] tree_b_q,    tree_b_d;

  // One extra bit of headroom: overflow shows up as the top two bits differing.
  logic [ACC_W:0] sum_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      lane_cnt_q  <= '0;
      chunk_cnt_q <= '0;
      len_q       <= '0;
      tree_a_q    <= '0;
      tree_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      lane_cnt_q  <= lane_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
      len_q       <= len_d;
      tree_a_q    <= tree_a_d;
      tree_b_q    <= tree_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    lane_cnt_d  = lane_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    len_d       = len_q;
    tree_a_d    = tree_a_q;
    tree_b_d    = tree_b_q;
    sum_ext     = {acc_q[ACC_W-1], acc_q} + {tree_sum[ACC_W-1], tree_sum};

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = '0;
          sat_d       = 1'b0;
          lane_cnt_d  = '0;
          chunk_cnt_d = '0;
          len_d       = cfg_len;
          tree_a_d    = '0;
          tree_b_d    = '0;
          // A zero-length job has nothing to load; present the cleared result.
          state_d     = (cfg_len == '0) ? OUT : LOAD;
        end
      end

      LOAD: begin
        if (io.in_valid) begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
              tree_a_d[8*i +: 8] = io.in_a;
              tree_b_d[8*i +: 8] = io.in_b;
            end
          end
          if (lane_cnt_q == LAST_LANE) begin
            lane_cnt_d = '0;
            state_d    = MAC;
          end else begin
            lane_cnt_d = lane_cnt_q + 1'b1;
          end
        end
      end

      MAC: begin
        if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
          acc_d = sum_ext[ACC_W] ? ACC_MIN : ACC_MAX;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_ext[ACC_W-1:0];
        end
        chunk_cnt_d = chunk_cnt_q + 1'b1;
        state_d     = (chunk_cnt_q == len_q - LEN_W'(1)) ? OUT : LOAD;
      end

      OUT: begin
        if (io.res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign io.in_ready  = (state_q == LOAD);
  assign io.res_valid = (state_q == OUT);
  assign io.res_data  = acc_q;
  assign io.res_sat   = sat_q;
  assign tree_a       = tree_a_q;
  assign tree_b       = tree_b_q;

endmodule
